fetch_unit: RTL and testbench

//  Instruction-fetch stage that sits directly downstream of the PC register.
//  - Reads the current PC and issues a request/ack transfer to instruction memory.
//  - Captures the returned word into the IF/ID holding register.
//  - Drives the PC's load-enable and next-value inputs: PC+4 on sequential flow,

---
 rtl/mips_pkg.sv | 27 ++
 rtl/fetch_unit_ifid.sv | 35 +++
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage types: FSM encoding, PC increment, widths.
// ALIGN_CHECK_EN adds the HALT state used on misaligned redirects.
package mips_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int PC_INC_DEF  = 4;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_HOLD  = 3'd2,
`ifdef ALIGN_CHECK_EN
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
`else
        ST_FLUSH = 3'd3
`endif
    } fetch_state_t;

    // A word fetch needs the two low address bits clear.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_ifid.sv
// IF/ID holding register: instruction, its PC and a valid flag.
// Load captures a new word; clear drops only the valid flag.
module ifid_reg
    import mips_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load,
    input  logic              Clear,
    input  logic [DATA_W-1:0] Instr_D,
    input  logic [ADDR_W-1:0] Pc_D,
    output logic              Instr_Valid,
    output logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] Instr_PC
);

    // Register the fetched word; load wins over clear.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Instr_Valid <= 1'b0;
            Instr       <= '0;
            Instr_PC    <= '0;
        end else if (Load) begin
            Instr_Valid <= 1'b1;
            Instr       <= Instr_D;
            Instr_PC    <= Pc_D;
        end else if (Clear) begin
            Instr_Valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: memory req/ack, next-PC mux, IF/ID handoff.
// Define ALIGN_CHECK_EN to halt with Fault on misaligned redirects.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_INC = PC_INC_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] PC_In,
    output logic              PC_LdEn,
    output logic [ADDR_W-1:0] NextPC,
    output logic              IMem_Req,
    output logic [ADDR_W-1:0] IMem_Addr,
    input  logic              IMem_Ack,
    input  logic [DATA_W-1:0] IMem_Rdata,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectAddr,
    output logic              Instr_Valid,
    output logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] Instr_PC,
    input  logic              Decode_Ready,
    output logic              Fault
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic         ifid_load;
    logic         ifid_clear;
    logic [ADDR_W-1:0] seq_pc;

    assign seq_pc    = PC_In + ADDR_W'(PC_INC);
    assign IMem_Addr = PC_In;

`ifdef ALIGN_CHECK_EN
    logic bad_redirect;
    logic fault_q;

    assign bad_redirect = Redirect
                        && misaligned(RedirectAddr[1:0]);
`endif

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, memory request and PC load selection.
    always_comb begin
        state_d    = state_q;
        PC_LdEn    = 1'b0;
        NextPC     = seq_pc;
        IMem_Req   = 1'b0;
        ifid_load  = 1'b0;
        ifid_clear = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                IMem_Req = 1'b1;
                if (Redirect) begin
                    PC_LdEn = 1'b1;
                    NextPC  = RedirectAddr;
                    if (!IMem_Ack) begin
                        state_d = ST_FLUSH;
                    end
                end else if (IMem_Ack) begin
                    PC_LdEn   = 1'b1;
                    ifid_load = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (Redirect) begin
                    PC_LdEn    = 1'b1;
                    NextPC     = RedirectAddr;
                    ifid_clear = 1'b1;
                    state_d    = ST_FETCH;
                end else if (Decode_Ready) begin
                    ifid_clear = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_FLUSH: begin
                IMem_Req = 1'b1;
                if (Redirect) begin
                    PC_LdEn = 1'b1;
                    NextPC  = RedirectAddr;
                end
                if (IMem_Ack) begin
                    state_d = ST_FETCH;
                end
            end
`ifdef ALIGN_CHECK_EN
            ST_HALT: begin
                ifid_clear = 1'b1;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef ALIGN_CHECK_EN
        if (bad_redirect && state_q != ST_IDLE
                && state_q != ST_HALT) begin
            PC_LdEn    = 1'b0;
            NextPC     = seq_pc;
            ifid_load  = 1'b0;
            ifid_clear = 1'b1;
            state_d    = ST_HALT;
        end
`endif
    end

`ifdef ALIGN_CHECK_EN
    // Sticky fault flag; only Reset clears it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fault_q <= 1'b0;
        end else if (bad_redirect && state_q != ST_IDLE
                     && state_q != ST_HALT) begin
            fault_q <= 1'b1;
        end
    end

    assign Fault = fault_q;
`else
    assign Fault = 1'b0;
`endif

    ifid_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ifid (
        .Clk         (Clk),
        .Reset       (Reset),
        .Load        (ifid_load),
        .Clear       (ifid_clear),
        .Instr_D     (IMem_Rdata),
        .Pc_D        (PC_In),
        .Instr_Valid (Instr_Valid),
        .Instr       (Instr),
        .Instr_PC    (Instr_PC)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vectors and corner
// sequences, then randomized traffic against a transaction-level model.
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] PC_In;
    logic        PC_LdEn;
    logic [31:0] NextPC;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ack = 1'b0;
    logic [31:0] IMem_Rdata = '0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectAddr = '0;
    logic        Instr_Valid;
    logic [31:0] Instr;
    logic [31:0] Instr_PC;
    logic        Decode_Ready = 1'b0;
    logic        Fault;

    int checks = 0;
    int failures = 0;

    fetch_unit dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .PC_In        (PC_In),
        .PC_LdEn      (PC_LdEn),
        .NextPC       (NextPC),
        .IMem_Req     (IMem_Req),
        .IMem_Addr    (IMem_Addr),
        .IMem_Ack     (IMem_Ack),
        .IMem_Rdata   (IMem_Rdata),
        .Redirect     (Redirect),
        .RedirectAddr (RedirectAddr),
        .Instr_Valid  (Instr_Valid),
        .Instr        (Instr),
        .Instr_PC     (Instr_PC),
        .Decode_Ready (Decode_Ready),
        .Fault        (Fault)
    );

    always #5 Clk = ~Clk;

    // PC register living upstream of the fetch stage.
    logic [31:0] pc_reg;
    always @(posedge Clk) begin
        if (Reset) pc_reg <= '0;
        else if (PC_LdEn) pc_reg <= NextPC;
    end
    assign PC_In = pc_reg;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        IMem_Ack = 1'b0;
        Redirect = 1'b0;
        Decode_Ready = 1'b0;
        @(negedge Clk);
        #1;
        chk("rst_valid", Instr_Valid, 0);
        chk("rst_instr", Instr, 0);
        chk("rst_ipc", Instr_PC, 0);
        chk("rst_req", IMem_Req, 0);
        chk("rst_fault", Fault, 0);
        chk("rst_pc", PC_In, 0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("idle_req", IMem_Req, 0);
        chk("idle_ld", PC_LdEn, 0);
    endtask

    task automatic do_fetch(input int wt, input int rw,
                            input logic [31:0] epc,
                            input logic [31:0] enext,
                            input bit hold);
        for (int i = 0; i <= wt; i++) begin
            @(negedge Clk);
            Redirect = 1'b0;
            Decode_Ready = 1'b0;
            IMem_Ack = (i == wt);
            IMem_Rdata = (i == wt) ? memf(epc) : 32'hBAD0_0000;
            #1;
            chk("f_req", IMem_Req, 1);
            chk("f_addr", IMem_Addr, epc);
            chk("f_valid", Instr_Valid, 0);
            if (i < wt) begin
                chk("f_ld_wait", PC_LdEn, 0);
            end else begin
                chk("f_ld", PC_LdEn, 1);
                chk("f_next", NextPC, enext);
            end
        end
        if (hold) begin
            for (int j = 0; j <= rw; j++) begin
                @(negedge Clk);
                IMem_Ack = 1'b0;
                Decode_Ready = (j == rw);
                #1;
                chk("h_valid", Instr_Valid, 1);
                chk("h_instr", Instr, memf(epc));
                chk("h_ipc", Instr_PC, epc);
                chk("h_req", IMem_Req, 0);
                chk("h_ld", PC_LdEn, 0);
            end
        end
    endtask

    typedef struct {
        int          wt;
        int          rw;
        logic [31:0] pc;
        logic [31:0] nxt;
    } vec_t;

    vec_t vecs[5];

    // Random-phase model state.
    logic [31:0] exp_pc;
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    bit          valid_exp;
    bit          flushing;
    bit          prev_wait;
    bit          started;
    int          wcnt;
    int          delivered;

    initial begin
        vecs[0] = '{0, 0, 32'h0,  32'h4};
        vecs[1] = '{0, 0, 32'h4,  32'h8};
        vecs[2] = '{0, 0, 32'h8,  32'hC};
        vecs[3] = '{0, 0, 32'hC,  32'h10};
        vecs[4] = '{3, 5, 32'h10, 32'h14};

        do_reset();
        foreach (vecs[k]) begin
            do_fetch(vecs[k].wt, vecs[k].rw, vecs[k].pc,
                     vecs[k].nxt, 1'b1);
        end

        // Redirect during a FETCH wait: stale word must be dropped.
        @(negedge Clk);
        Decode_Ready = 1'b0;
        IMem_Ack = 1'b0;
        Redirect = 1'b1;
        RedirectAddr = 32'h400;
        #1;
        chk("rd_req", IMem_Req, 1);
        chk("rd_ld", PC_LdEn, 1);
        chk("rd_next", NextPC, 32'h400);
        @(negedge Clk);
        Redirect = 1'b0;
        #1;
        chk("fl_req", IMem_Req, 1);
        chk("fl_ld", PC_LdEn, 0);
        @(negedge Clk);
        IMem_Ack = 1'b1;
        IMem_Rdata = 32'hDEADBEEF;
        #1;
        chk("fl_req2", IMem_Req, 1);
        chk("fl_ld2", PC_LdEn, 0);
        do_fetch(0, 0, 32'h400, 32'h404, 1'b1);

        // Redirect coincident with Ack, then PC wrap at the top.
        @(negedge Clk);
        IMem_Ack = 1'b1;
        IMem_Rdata = 32'h0BADF00D;
        Redirect = 1'b1;
        RedirectAddr = 32'hFFFF_FFFC;
        #1;
        chk("ra_ld", PC_LdEn, 1);
        chk("ra_next", NextPC, 32'hFFFF_FFFC);
        do_fetch(0, 0, 32'hFFFF_FFFC, 32'h0, 1'b1);
        do_fetch(0, 0, 32'h0, 32'h4, 1'b0);

        // Redirect in HOLD beats a simultaneous Decode_Ready.
        @(negedge Clk);
        IMem_Ack = 1'b0;
        Decode_Ready = 1'b1;
        Redirect = 1'b1;
        RedirectAddr = 32'h100;
        #1;
        chk("hr_valid", Instr_Valid, 1);
        chk("hr_ld", PC_LdEn, 1);
        chk("hr_next", NextPC, 32'h100);
        @(negedge Clk);
        Redirect = 1'b0;
        Decode_Ready = 1'b0;
        #1;
        chk("hr_valid2", Instr_Valid, 0);
        chk("hr_req", IMem_Req, 1);
        chk("hr_addr", IMem_Addr, 32'h100);
        do_fetch(0, 0, 32'h100, 32'h104, 1'b1);

        // Reset in the middle of a FETCH wait.
        @(negedge Clk);
        IMem_Ack = 1'b0;
        #1;
        chk("mr_req", IMem_Req, 1);
        do_reset();

        // Misaligned redirect.
        @(negedge Clk);
        Redirect = 1'b1;
        RedirectAddr = 32'h402;
        #1;
`ifdef ALIGN_CHECK_EN
        chk("ma_ld", PC_LdEn, 0);
        @(negedge Clk);
        Redirect = 1'b0;
        #1;
        chk("ma_fault", Fault, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            #1;
            chk("ma_req", IMem_Req, 0);
            chk("ma_valid", Instr_Valid, 0);
            chk("ma_fault2", Fault, 1);
        end
`else
        chk("ma_ld", PC_LdEn, 1);
        chk("ma_next", NextPC, 32'h402);
        @(negedge Clk);
        Redirect = 1'b0;
        #1;
        chk("ma_fault", Fault, 0);
        chk("ma_req", IMem_Req, 1);
        chk("ma_addr", IMem_Addr, 32'h402);
`endif

        // Randomized traffic against a transaction-level model.
        do_reset();
        exp_pc = '0;
        valid_exp = 0;
        flushing = 0;
        prev_wait = 0;
        started = 0;
        delivered = 0;
        wcnt = $urandom_range(0, 3);
        for (int c = 0; c < 2000; c++) begin
            @(negedge Clk);
            Decode_Ready = 1'($urandom_range(0, 1));
            Redirect = 1'b0;
            if (started && $urandom_range(0, 7) == 0) begin
                Redirect = 1'b1;
                RedirectAddr = 32'($urandom_range(0, 1023)) << 2;
            end
            IMem_Ack = 1'b0;
            if (IMem_Req) begin
                if (wcnt == 0) begin
                    IMem_Ack = 1'b1;
                    wcnt = $urandom_range(0, 3);
                end else begin
                    wcnt--;
                end
            end
            IMem_Rdata = memf(IMem_Addr);
            #1;
            if (prev_wait) chk("r_req_held", IMem_Req, 1);
            chk("r_valid", Instr_Valid, valid_exp);
            if (valid_exp) begin
                chk("r_ipc", Instr_PC, held_pc);
                chk("r_instr", Instr, held_instr);
                chk("r_no_prefetch", IMem_Req, 0);
            end
            if (IMem_Req) chk("r_addr", IMem_Addr, exp_pc);
            if (Redirect) begin
                chk("r_rd_ld", PC_LdEn, 1);
                chk("r_rd_next", NextPC, RedirectAddr);
            end else if (IMem_Req && IMem_Ack && !flushing) begin
                chk("r_seq_ld", PC_LdEn, 1);
                chk("r_seq_next", NextPC, exp_pc + 32'd4);
            end else begin
                chk("r_no_ld", PC_LdEn, 0);
            end
            prev_wait = IMem_Req && !IMem_Ack;
            if (IMem_Req) started = 1;
            if (Redirect) begin
                valid_exp = 0;
                exp_pc = RedirectAddr;
                flushing = IMem_Req && !IMem_Ack;
            end else begin
                if (valid_exp && Decode_Ready) begin
                    valid_exp = 0;
                    delivered++;
                end
                if (IMem_Req && IMem_Ack) begin
                    if (flushing) begin
                        flushing = 0;
                    end else begin
                        valid_exp = 1;
                        held_pc = exp_pc;
                        held_instr = memf(exp_pc);
                        exp_pc = exp_pc + 32'd4;
                    end
                end
            end
        end
        chk("r_progress", 32'(delivered > 20), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
